// File: rtl/mac_tile_scheduler.sv
`default_nettype none
// ============================================================================
// mac_tile_scheduler : credit-throttled tile issue controller with result FIFO
// Optional build macro: TILE_SCHED_PERF_EN (issue/stall performance counters)
// Revision: 1.0
// ============================================================================
module mac_tile_scheduler #(
    parameter int N_ARRAY     = 4,
    parameter int N_BANK      = 12,
    parameter int BANK_STRIDE = 3,
    parameter int ADDR_W      = 10,
    parameter int RD_LAT      = 1,
    parameter int RES_W       = 128,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [CNT_W-1:0]                   cfg_num_tiles,
    input  logic [ADDR_W-1:0]                  cfg_base_addr,
    input  logic [$clog2(N_BANK)-1:0]          cfg_base_bank,
    output logic                               busy,
    output logic                               done,
    output logic [N_BANK-1:0]                  en_bank,
    output logic [N_BANK*ADDR_W-1:0]           addr_bank,
    output logic                               arr_valid_in,
    output logic [N_ARRAY*$clog2(N_BANK)-1:0]  arr_bank_sel,
    input  logic                               red_valid,
    input  logic [RES_W-1:0]                   red_data,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [RES_W-1:0]                   res_data,
    output logic                               err_overflow
`ifdef TILE_SCHED_PERF_EN
    ,
    output logic [31:0]                        perf_issue_cnt,
    output logic [31:0]                        perf_stall_cnt
`endif
);

    localparam int c_bsel_w = $clog2(N_BANK);
    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;

    localparam logic [c_bsel_w:0]   c_nbank     = (c_bsel_w+1)'(N_BANK);
    localparam logic [c_bsel_w-1:0] c_last_bank = c_bsel_w'(N_BANK - 1);
    localparam logic [c_cnt_w:0]    c_depth     = (c_cnt_w+1)'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0]  c_full_cnt  = c_cnt_w'(FIFO_DEPTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    if (N_ARRAY * BANK_STRIDE > N_BANK) begin : g_err_banks
        $error("mac_tile_scheduler: N_ARRAY*BANK_STRIDE exceeds N_BANK");
    end
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
        $error("mac_tile_scheduler: FIFO_DEPTH must be a power of 2");
    end
    if (RD_LAT < 1) begin : g_err_lat
        $error("mac_tile_scheduler: RD_LAT must be at least 1");
    end

    logic [1:0]                  r_state;
    logic [CNT_W-1:0]            r_num_tiles;
    logic [CNT_W-1:0]            r_tile_idx;
    logic [ADDR_W-1:0]           r_cur_addr;
    logic [c_bsel_w-1:0]         r_bank0;
    logic [c_cnt_w-1:0]          r_inflight;
    logic [c_cnt_w-1:0]          r_fifo_count;
    logic [c_ptr_w-1:0]          r_wr_ptr;
    logic [c_ptr_w-1:0]          r_rd_ptr;
    logic [RES_W-1:0]            r_mem [FIFO_DEPTH];
    logic [RD_LAT-1:0]           r_vld_pipe;
    logic [N_ARRAY*c_bsel_w-1:0] r_sel_pipe [RD_LAT];

    logic                        w_accept;
    logic                        w_issue;
    logic                        w_last;
    logic                        w_retire;
    logic                        w_full;
    logic                        w_push;
    logic                        w_pop;
    logic [c_cnt_w:0]            w_credit_sum;
    logic [c_bsel_w:0]           w_bb_ext;
    logic [c_bsel_w-1:0]         w_base_bank;
    logic [N_ARRAY*c_bsel_w-1:0] w_sel_flat;

    assign w_accept = (r_state == c_st_idle) && start;

    // A push lands on the same edge that retires its inflight credit, so
    // inflight + fifo_count already covers every outstanding result.
    assign w_credit_sum = {1'b0, r_inflight} + {1'b0, r_fifo_count};
    assign w_issue      = (r_state == c_st_issue) && (w_credit_sum < c_depth);
    assign w_last       = ((r_tile_idx + 1'b1) == r_num_tiles);
    assign w_retire     = red_valid && (r_inflight != '0);

    assign w_bb_ext    = {1'b0, cfg_base_bank};
    assign w_base_bank = (w_bb_ext >= c_nbank) ? c_bsel_w'(w_bb_ext - c_nbank)
                                               : cfg_base_bank;

    for (genvar gi = 0; gi < N_ARRAY; gi++) begin : g_arr
        localparam logic [c_bsel_w:0] c_off = (c_bsel_w+1)'(BANK_STRIDE * gi);
        logic [c_bsel_w:0] w_sum;
        assign w_sum = {1'b0, r_bank0} + c_off;
        assign w_sel_flat[gi*c_bsel_w +: c_bsel_w] =
            (w_sum >= c_nbank) ? c_bsel_w'(w_sum - c_nbank) : w_sum[c_bsel_w-1:0];
    end

    for (genvar gb = 0; gb < N_BANK; gb++) begin : g_bank
        logic w_hit;
        always_comb begin
            w_hit = 1'b0;
            for (int i = 0; i < N_ARRAY; i++) begin
                if (w_sel_flat[i*c_bsel_w +: c_bsel_w] == c_bsel_w'(gb)) begin
                    w_hit = 1'b1;
                end
            end
        end
        assign en_bank[gb]                   = w_issue && w_hit;
        assign addr_bank[gb*ADDR_W +: ADDR_W] = en_bank[gb] ? r_cur_addr : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            busy        <= 1'b0;
            done        <= 1'b0;
            r_num_tiles <= '0;
            r_tile_idx  <= '0;
            r_cur_addr  <= '0;
            r_bank0     <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        busy        <= 1'b1;
                        r_num_tiles <= cfg_num_tiles;
                        r_tile_idx  <= '0;
                        r_cur_addr  <= cfg_base_addr;
                        r_bank0     <= w_base_bank;
                        r_state     <= (cfg_num_tiles == '0) ? c_st_done : c_st_issue;
                    end
                end
                c_st_issue: begin
                    if (w_issue) begin
                        r_tile_idx <= r_tile_idx + 1'b1;
                        r_cur_addr <= r_cur_addr + 1'b1;
                        r_bank0    <= (r_bank0 == c_last_bank) ? '0 : r_bank0 + 1'b1;
                        if (w_last) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    if (r_inflight == '0) begin
                        r_state <= c_st_done;
                    end
                end
                default: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else if (w_issue && !w_retire) begin
            r_inflight <= r_inflight + 1'b1;
        end else if (!w_issue && w_retire) begin
            r_inflight <= r_inflight - 1'b1;
        end
    end

    // Bank-select stages only load on valid so the output holds between tiles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_sel_pipe[k] <= '0;
            end
        end else begin
            r_vld_pipe[0] <= w_issue;
            if (w_issue) begin
                r_sel_pipe[0] <= w_sel_flat;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                if (r_vld_pipe[k-1]) begin
                    r_sel_pipe[k] <= r_sel_pipe[k-1];
                end
            end
        end
    end

    assign arr_valid_in = r_vld_pipe[RD_LAT-1];
    assign arr_bank_sel = r_sel_pipe[RD_LAT-1];

    assign w_full    = (r_fifo_count == c_full_cnt);
    assign res_valid = (r_fifo_count != '0);
    assign w_pop     = res_valid && res_ready;
    assign w_push    = red_valid && (!w_full || w_pop);
    assign res_data  = res_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_fifo_count <= r_fifo_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_fifo_count <= r_fifo_count - 1'b1;
            end
            if (red_valid && w_full && !w_pop) begin
                err_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= red_data;
        end
    end

`ifdef TILE_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else if (w_accept) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_issue && (perf_issue_cnt != '1)) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if ((r_state == c_st_issue) && !w_issue && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_tile_scheduler.sv
`default_nettype none
// tb_mac_tile_scheduler : randomized bench against a queue-based job/FIFO reference model.
module tb_mac_tile_scheduler;
    localparam int N_ARRAY     = 4;
    localparam int N_BANK      = 12;
    localparam int BANK_STRIDE = 3;
    localparam int ADDR_W      = 10;
    localparam int RD_LAT      = 1;
    localparam int RES_W       = 128;
    localparam int FIFO_DEPTH  = 8;
    localparam int CNT_W       = 16;
    localparam int BW          = $clog2(N_BANK);
    localparam int PIPE_LAT    = RD_LAT + 5;
    localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_DRAIN = 2, PH_DONE = 3;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      start = 1'b0;
    logic [CNT_W-1:0]          cfg_num_tiles = '0;
    logic [ADDR_W-1:0]         cfg_base_addr = '0;
    logic [BW-1:0]             cfg_base_bank = '0;
    logic                      busy, done;
    logic [N_BANK-1:0]         en_bank;
    logic [N_BANK*ADDR_W-1:0]  addr_bank;
    logic                      arr_valid_in;
    logic [N_ARRAY*BW-1:0]     arr_bank_sel;
    logic                      red_valid = 1'b0;
    logic [RES_W-1:0]          red_data = '0;
    logic                      res_valid;
    logic                      res_ready = 1'b0;
    logic [RES_W-1:0]          res_data;
    logic                      err_overflow;
`ifdef TILE_SCHED_PERF_EN
    logic [31:0]               perf_issue_cnt, perf_stall_cnt;
`endif

    mac_tile_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_num_tiles(cfg_num_tiles), .cfg_base_addr(cfg_base_addr), .cfg_base_bank(cfg_base_bank),
        .busy(busy), .done(done), .en_bank(en_bank), .addr_bank(addr_bank),
        .arr_valid_in(arr_valid_in), .arr_bank_sel(arr_bank_sel),
        .red_valid(red_valid), .red_data(red_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err_overflow(err_overflow)
`ifdef TILE_SCHED_PERF_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0, n_iss_obs = 0, n_pop_obs = 0;
    int m_ph = PH_IDLE, m_num = 0, m_t = 0, m_base = 0, m_bank = 0, m_inflight = 0;
    bit m_done = 0, m_err = 0, m_av = 0, force_red = 0;
    logic [N_ARRAY*BW-1:0] m_asel = '0;
    logic [RES_W-1:0]      m_fifo[$];
    bit                    hq_v[$];
    logic [N_ARRAY*BW-1:0] hq_s[$];
    bit                    env_q[$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_ph = PH_IDLE; m_num = 0; m_t = 0; m_inflight = 0;
        m_done = 0; m_err = 0; m_av = 0; m_asel = '0;
        m_fifo.delete(); hq_v.delete(); hq_s.delete(); env_q.delete();
    endfunction

    function automatic void set_ready(input int mode);
        if (mode == 0)      res_ready = 1'b1;
        else if (mode == 1) res_ready = 1'b0;
        else                res_ready = 1'($urandom_range(0, 1));
    endfunction

    // Expected bank vectors for tile t from the rotation/address formulas.
    function automatic void exp_vec(input int t, input bit iss, output logic [N_BANK-1:0] en,
                                    output logic [N_BANK*ADDR_W-1:0] addr, output logic [N_ARRAY*BW-1:0] sel);
        int b;
        en = '0; addr = '0; sel = '0;
        for (int i = 0; i < N_ARRAY; i++) begin
            b = (m_bank + t + BANK_STRIDE * i) % N_BANK;
            sel[i*BW +: BW] = BW'(b);
            if (iss) begin
                en[b] = 1'b1;
                addr[b*ADDR_W +: ADDR_W] = ADDR_W'((m_base + t) % (1 << ADDR_W));
            end
        end
    endfunction

    // Check this cycle's outputs, drive the pipeline model, then advance the reference by one edge.
    task automatic cycle();
        logic [N_BANK-1:0]        e_en;
        logic [N_BANK*ADDR_W-1:0] e_addr;
        logic [N_ARRAY*BW-1:0]    e_sel, s_tmp;
        logic [RES_W-1:0]         e_data;
        bit iss, rv, pop, push;
        int inf_old;
        iss = (m_ph == PH_ISSUE) && (m_inflight + m_fifo.size() < FIFO_DEPTH);
        exp_vec(m_t, iss, e_en, e_addr, e_sel);
        e_data = '0;
        if (m_fifo.size() != 0) e_data = m_fifo[0];
        check("busy", busy, m_ph != PH_IDLE);
        check("done", done, m_done);
        check("en_bank", en_bank, e_en);
        check("addr_bank", addr_bank, e_addr);
        check("arr_valid_in", arr_valid_in, m_av);
        check("arr_bank_sel", arr_bank_sel, m_asel);
        check("res_valid", res_valid, m_fifo.size() != 0);
        check("res_data", res_data, e_data);
        check("err_overflow", err_overflow, m_err);
        if (en_bank != '0) n_iss_obs++;
        if (res_valid && res_ready) n_pop_obs++;
        env_q.push_back(iss);
        rv = 1'b0;
        if (env_q.size() > PIPE_LAT) rv = env_q.pop_front();
        rv = rv | force_red;
        red_valid = rv;
        red_data = rv ? {$urandom(), $urandom(), $urandom(), $urandom()} : '0;
        @(posedge clk);
        pop = (m_fifo.size() != 0) && res_ready;
        push = rv;
        if (rv && m_fifo.size() == FIFO_DEPTH && !pop) begin
            m_err = 1'b1;
            push = 1'b0;
        end
        if (pop) void'(m_fifo.pop_front());
        if (push) m_fifo.push_back(red_data);
        inf_old = m_inflight;
        if (iss) m_inflight++;
        if (rv && inf_old > 0) m_inflight--;
        hq_v.push_back(iss);
        hq_s.push_back(e_sel);
        m_av = 1'b0;
        if (hq_v.size() >= RD_LAT) begin
            m_av  = hq_v.pop_front();
            s_tmp = hq_s.pop_front();
            if (m_av) m_asel = s_tmp;
        end
        m_done = 1'b0;
        case (m_ph)
            PH_IDLE: if (start) begin
                m_num = int'(cfg_num_tiles); m_base = int'(cfg_base_addr); m_bank = int'(cfg_base_bank);
                m_t = 0;
                m_ph = (m_num == 0) ? PH_DONE : PH_ISSUE;
            end
            PH_ISSUE: if (iss) begin
                m_t++;
                if (m_t == m_num) m_ph = PH_DRAIN;
            end
            PH_DRAIN: if (inf_old == 0) m_ph = PH_DONE;
            default: begin
                m_done = 1'b1;
                m_ph = PH_IDLE;
            end
        endcase
        #1;
    endtask

    task automatic run_cycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            set_ready(mode);
            cycle();
        end
    endtask

    task automatic start_job(input int num, input int base, input int bank);
        cfg_num_tiles = CNT_W'(num);
        cfg_base_addr = ADDR_W'(base);
        cfg_base_bank = BW'(bank);
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic finish_job(input int mode);
        int budget = 0;
        while ((m_ph != PH_IDLE || m_done) && budget < 1000) begin
            set_ready(mode);
            cycle();
            budget++;
        end
        check("job_timeout", budget >= 1000, 1'b0);
    endtask

    task automatic drain();
        int budget = 0;
        while (m_fifo.size() != 0 && budget < 200) begin
            set_ready(0);
            cycle();
            budget++;
        end
        check("drain_timeout", budget >= 200, 1'b0);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_en_bank", en_bank, '0);
        check("rst_res_valid", res_valid, 1'b0);
        rst_n = 1'b1;
        run_cycles(2, 0);

        // Job 1: 12 tiles, unthrottled.
        n_iss_obs = 0; n_pop_obs = 0;
        res_ready = 1'b1;
        start_job(12, 0, 0);
        finish_job(0);
        drain();
        check("job1_issues", n_iss_obs, 12);
        check("job1_results", n_pop_obs, 12);

        // Backpressure: credit caps issue at FIFO_DEPTH.
        n_iss_obs = 0; n_pop_obs = 0;
        res_ready = 1'b0;
        start_job(20, 5, 4);
        run_cycles(40, 1);
        check("bp_issued_before_release", n_iss_obs, FIFO_DEPTH);
        finish_job(0);
        drain();
        check("bp_issues", n_iss_obs, 20);
        check("bp_results", n_pop_obs, 20);

        // Zero-tile job.
        n_iss_obs = 0;
        start_job(0, 7, 3);
        finish_job(0);
        check("zero_issues", n_iss_obs, 0);

        // Address and bank wrap.
        n_iss_obs = 0;
        start_job(3, 1022, 11);
        finish_job(0);
        drain();
        check("wrap_issues", n_iss_obs, 3);

        // start pulsed during ISSUE is ignored.
        n_iss_obs = 0;
        start_job(10, 100, 2);
        run_cycles(3, 0);
        cfg_num_tiles = 16'd3;
        start = 1'b1;
        run_cycles(2, 0);
        start = 1'b0;
        finish_job(0);
        drain();
        check("restart_ignored_issues", n_iss_obs, 10);

        // Overflow on a full FIFO.
        res_ready = 1'b0;
        start_job(FIFO_DEPTH, 300, 6);
        finish_job(1);
        force_red = 1'b1;
        run_cycles(1, 1);
        force_red = 1'b0;
        run_cycles(3, 1);
        check("ovf_set", err_overflow, 1'b1);
        drain();
        check("ovf_sticky", err_overflow, 1'b1);

        // Asynchronous reset mid-ISSUE.
        start_job(15, 50, 9);
        run_cycles(4, 0);
        #2;
        rst_n = 1'b0;
        red_valid = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_en_bank", en_bank, '0);
        check("arst_addr_bank", addr_bank, '0);
        check("arst_arr_valid", arr_valid_in, 1'b0);
        check("arst_arr_sel", arr_bank_sel, '0);
        check("arst_res_valid", res_valid, 1'b0);
        check("arst_res_data", res_data, '0);
        check("arst_err", err_overflow, 1'b0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_iss_obs = 0;
        start_job(5, 900, 1);
        finish_job(0);
        drain();
        check("post_rst_issues", n_iss_obs, 5);

        // Random jobs with random downstream readiness.
        for (int j = 0; j < 6; j++) begin
            n_iss_obs = 0;
            start_job(int'($urandom_range(1, 20)), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, N_BANK - 1)));
            finish_job(2);
            drain();
            check("rand_issues", n_iss_obs, m_num);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
